// File: rtl/fg_coord_gen.sv
// Pixel-stream front end: binarises a scanned frame, filters short dark runs and
// emits registered foreground coordinates for the downstream extent trackers.
//
// state    | meaning
// S_IDLE   | waiting for frame_start with pix_valid; other pixels are ignored
// S_ACTIVE | scanning a frame; each accepted pixel advances x/y
module fg_coord_gen #(
  parameter int          H_ACTIVE = 480,
  parameter int          V_ACTIVE = 272,
  parameter logic [7:0]  THRESH   = 8'd128,
  parameter int          RUN_MIN  = 3
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_gray,
  output logic [8:0]  coord_x,
  output logic [8:0]  coord_y,
  output logic        wren,
  output logic        frame_done,
  output logic [16:0] fg_count
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  localparam logic [8:0] X_LAST  = 9'(H_ACTIVE - 1);
  localparam logic [8:0] Y_LAST  = 9'(V_ACTIVE - 1);
  localparam logic [3:0] RUN_SAT = 4'(RUN_MIN);
  localparam logic [3:0] RUN_PRE = 4'(RUN_MIN - 1);
  localparam logic [8:0] RUN_OFS = 9'(RUN_MIN - 1);

  logic [0:0] state;
  logic [8:0] x_cnt, y_cnt;
  logic [3:0] run_cnt;

  logic       accept, fg, last_pix, line_end;
  logic       hit_start, hit_sat, hit;
  logic [8:0] cur_x, cur_y;
  logic [3:0] run_base, run_next;

  // frame_start re-anchors the scan at (0,0), even mid-frame
  always_comb begin
    accept    = pix_valid & (frame_start | (state == S_ACTIVE));
    cur_x     = frame_start ? 9'd0 : x_cnt;
    cur_y     = frame_start ? 9'd0 : y_cnt;
    run_base  = (cur_x == 9'd0) ? 4'd0 : run_cnt;
    fg        = (pix_gray < THRESH);
    hit_start = fg & (run_base == RUN_PRE);
    hit_sat   = fg & (run_base == RUN_SAT);
    hit       = hit_start | hit_sat;
    line_end  = (cur_x == X_LAST);
    last_pix  = line_end & (cur_y == Y_LAST);
    run_next  = 4'd0;
    if (fg)
      run_next = (run_base == RUN_SAT) ? RUN_SAT : run_base + 4'd1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      x_cnt      <= 9'd0;
      y_cnt      <= 9'd0;
      run_cnt    <= 4'd0;
      coord_x    <= 9'd0;
      coord_y    <= 9'd0;
      wren       <= 1'b0;
      frame_done <= 1'b0;
      fg_count   <= 17'd0;
    end else begin
      frame_done <= accept & last_pix;
      if (!accept) begin
        wren <= 1'b0;
      end else begin
        state   <= last_pix ? S_IDLE : S_ACTIVE;
        x_cnt   <= line_end ? 9'd0 : cur_x + 9'd1;
        y_cnt   <= line_end ? (last_pix ? 9'd0 : cur_y + 9'd1) : cur_y;
        run_cnt <= run_next;
        wren    <= hit;
        // A newly qualified run reports its first pixel, later ones report themselves
        if (hit) begin
          coord_x <= hit_sat ? cur_x : cur_x - RUN_OFS;
          coord_y <= cur_y;
        end
        fg_count <= (frame_start ? 17'd0 : fg_count) + {16'd0, hit};
      end
    end
  end

endmodule
